// File: rtl/alu_op_sequencer.sv
// Decodes one ALU op per op_valid/op_ready handshake into a one-hot mux select and captures the result.
// sel in cycle N+1, res_valid from N+2 (illegal opcodes: N+1); op_ready low until the result is taken on res_ready.
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       opcode,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [SEL_W-1:0] sel,
    output logic             sub_mode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    localparam logic [3:0] OP_SUB = 4'd8;

    state_t state, state_nxt;
    req_t   req_q;
    logic   legal;

    // Opcodes at or beyond the select width have no mux input behind them.
    assign legal = (32'(opcode) < 32'(SEL_W));

    assign alu_a = req_q.a;
    assign alu_b = req_q.b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        sel       = '0;
        sub_mode  = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_nxt = legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                sel       = SEL_W'(1) << req_q.opcode;
                sub_mode  = (req_q.opcode == OP_SUB);
                state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q    <= '0;
            res_out  <= '0;
            err      <= 1'b0;
            acc      <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (legal) begin
                            req_q.opcode <= opcode;
                            req_q.a      <= use_acc ? acc : a_in;
                            req_q.b      <= b_in;
                        end else begin
                            res_out <= '0;
                            err     <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res_out  <= alu_res;
                    acc      <= alu_res;
                    err      <= 1'b0;
                    op_count <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with a behavioural ALU mux and result model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  opcode;
    logic        use_acc;
    logic [15:0] a_in, b_in;
    logic [11:0] sel;
    logic        sub_mode;
    logic [15:0] alu_a, alu_b, alu_res;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_out;
    logic        err;
    logic [15:0] acc;
    logic [7:0]  op_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_acc;
    logic [7:0]  m_cnt;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .use_acc   (use_acc),
        .a_in      (a_in),
        .b_in      (b_in),
        .sel       (sel),
        .sub_mode  (sub_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .err       (err),
        .acc       (acc),
        .op_count  (op_count)
    );

    // Downstream ALU output mux; 16'hDEAD whenever nothing is selected.
    always_comb begin
        alu_res = 16'hDEAD;
        case (sel)
            12'h001: alu_res = alu_a & alu_b;
            12'h002: alu_res = alu_a | alu_b;
            12'h004: alu_res = ~alu_a;
            12'h008: alu_res = alu_a ^ alu_b;
            12'h010: alu_res = ~(alu_a & alu_b);
            12'h020: alu_res = ~(alu_a | alu_b);
            12'h040: alu_res = ~(alu_a ^ alu_b);
            12'h080, 12'h100: alu_res = sub_mode ? alu_a - alu_b : alu_a + alu_b;
            12'h200: alu_res = alu_a >> 1;
            12'h400: alu_res = alu_a << 1;
            12'h800: alu_res = 16'h0000;
            default: alu_res = 16'hDEAD;
        endcase
    end

    function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            0:  return a & b;
            1:  return a | b;
            2:  return 16'hFFFF - a;
            3:  return a ^ b;
            4:  return 16'hFFFF - (a & b);
            5:  return 16'hFFFF - (a | b);
            6:  return 16'hFFFF - (a ^ b);
            7:  return 16'((ia + ib) % 65536);
            8:  return 16'((ia - ib + 65536) % 65536);
            9:  return 16'(ia / 2);
            10: return 16'((ia * 2) % 65536);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        op_valid = 1'($urandom);
        opcode   = 4'($urandom);
        use_acc  = 1'($urandom);
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
    endtask

    // One request from IDLE through result consumption, holding res_ready low for `hold` cycles.
    task automatic do_op(input int op, input logic [15:0] a, input logic [15:0] b,
                         input logic ua, input int hold);
        int          n;
        logic [15:0] a_eff, exp_res, held_res;
        logic        exp_err;
        n = 0;
        while (!op_ready && n < 10) begin
            step();
            n++;
        end
        check("ready_before_issue", 32'(op_ready), 32'd1);
        a_eff    = ua ? m_acc : a;
        op_valid = 1'b1;
        opcode   = 4'(op);
        use_acc  = ua;
        a_in     = a;
        b_in     = b;
        res_ready = 1'b0;
        step();
        scramble_inputs();
        if (op < 12) begin
            exp_res = ref_alu(op, a_eff, b);
            exp_err = 1'b0;
            check("exec_sel", 32'(sel), 32'(1) << op);
            check("exec_sub_mode", 32'(sub_mode), (op == 8) ? 32'd1 : 32'd0);
            check("exec_op_ready", 32'(op_ready), 32'd0);
            check("exec_res_valid", 32'(res_valid), 32'd0);
            check("exec_alu_a", 32'(alu_a), 32'(a_eff));
            check("exec_alu_b", 32'(alu_b), 32'(b));
            step();
            scramble_inputs();
            m_acc = exp_res;
            m_cnt = m_cnt + 8'd1;
        end else begin
            exp_res = 16'h0000;
            exp_err = 1'b1;
            check("illegal_sel", 32'(sel), 32'd0);
        end
        check("done_res_valid", 32'(res_valid), 32'd1);
        check("done_res_out", 32'(res_out), 32'(exp_res));
        check("done_err", 32'(err), 32'(exp_err));
        check("done_acc", 32'(acc), 32'(m_acc));
        check("done_op_count", 32'(op_count), 32'(m_cnt));
        check("done_sel", 32'(sel), 32'd0);
        held_res = res_out;
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1;
            step();
            scramble_inputs();
            op_valid = 1'b1;
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_out", 32'(res_out), 32'(held_res));
            check("hold_err", 32'(err), 32'(exp_err));
            check("hold_op_ready", 32'(op_ready), 32'd0);
            check("hold_op_count", 32'(op_count), 32'(m_cnt));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        op_valid  = 1'b0;
        check("release_res_valid", 32'(res_valid), 32'd0);
        check("release_op_ready", 32'(op_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        opcode    = 4'd0;
        use_acc   = 1'b0;
        a_in      = 16'h0000;
        b_in      = 16'h0000;
        res_ready = 1'b0;
        m_acc     = 16'h0000;
        m_cnt     = 8'd0;

        step();
        step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_res_out", 32'(res_out), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_sub_mode", 32'(sub_mode), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_op_ready", 32'(op_ready), 32'd1);

        do_op(0, 16'h00FF, 16'h0F0F, 1'b0, 0);
        check("and_result", 32'(res_out), 32'h000F);
        do_op(8, 16'h0005, 16'h0007, 1'b0, 1);
        check("sub_result", 32'(acc), 32'hFFFE);
        do_op(1, 16'h1234, 16'h0000, 1'b0, 0);
        do_op(7, 16'hFFFF, 16'h0001, 1'b1, 0);
        check("use_acc_result", 32'(acc), 32'h1235);
        do_op(13, 16'hAAAA, 16'h5555, 1'b0, 5);
        check("illegal_acc_kept", 32'(acc), 32'h1235);
        do_op(11, 16'hBEEF, 16'hCAFE, 1'b0, 0);

        // Reset while in EXEC: the request must vanish without a result.
        op_valid = 1'b1;
        opcode   = 4'd3;
        use_acc  = 1'b0;
        a_in     = 16'h1111;
        b_in     = 16'h2222;
        step();
        op_valid = 1'b0;
        check("pre_rst_exec_sel", 32'(sel), 32'h008);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_acc = 16'h0000;
        m_cnt = 8'd0;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_rst_res_valid", 32'(res_valid), 32'd0);
            check("after_rst_op_ready", 32'(op_ready), 32'd1);
        end

        for (int i = 0; i < 256; i++) begin
            do_op(int'($urandom_range(0, 11)), 16'($urandom), 16'($urandom),
                  1'($urandom), int'($urandom_range(0, 2)));
        end
        check("op_count_wrap", 32'(op_count), 32'd0);

        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the 16-bit ALU output multiplexer.
- Accepts one operation per valid/ready handshake and decodes a 4-bit opcode into the 12-bit one-hot select the multiplexer consumes.
- Drives registered operands to the function units, captures the multiplexer's 16-bit result into an accumulator, and presents it on a valid/ready output port.

Parameters:
- WIDTH, 16, datapath width of operands, result and accumulator.
- SEL_W, 12, width of the one-hot multiplexer select.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- op_valid  input  1  upstream request valid.
- op_ready  output  1  block can accept a request.
- opcode  input  4  operation code; map below.
- use_acc  input  1  1 = operand A taken from accumulator instead of a_in.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- sel  output  SEL_W  one-hot select to the ALU output mux; all-zero when not executing.
- sub_mode  output  1  1 during SUB execution (add/subtract unit control).
- alu_a  output  WIDTH  registered operand A to the function units.
- alu_b  output  WIDTH  registered operand B to the function units.
- alu_res  input  WIDTH  result returned from the ALU output mux.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_out  output  WIDTH  captured result.
- err  output  1  qualifies res_valid; 1 = illegal opcode.
- acc  output  WIDTH  accumulator value.
- op_count  output  CNT_W  completed legal operations, wraps modulo 2^CNT_W.

Behaviour:
- Opcode map; sel bit index equals the opcode value:
  - 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR.
  - 7 ADD, 8 SUB, 9 SHRIGHT, 10 SHLEFT, 11 CLEAR.
  - 12–15 illegal.
- Reset, on the rising clk edge with rst_n=0 and regardless of state:
  - State goes to IDLE.
  - sel, sub_mode, alu_a, alu_b, res_out, acc and op_count go to 0.
  - res_valid and err go to 0.
  - op_ready goes to 1 in the cycle after reset deasserts.
  - Reset mid-operation discards the in-flight request; no result is produced.
- State machine: IDLE, EXEC, DONE.
- IDLE:
  - op_ready=1 and sel=0.
  - On op_valid=1 with a legal opcode:
    - Latch alu_a (acc if use_acc=1, otherwise a_in), alu_b=b_in and the opcode.
    - Go to EXEC.
  - On op_valid=1 with an illegal opcode:
    - Set res_out=0 and err=1.
    - Leave acc, alu_a and alu_b unchanged.
    - Go to DONE.
- EXEC, exactly one cycle:
  - op_ready=0.
  - sel=1<<opcode, decoded from the latched opcode; sub_mode=1 only for opcode 8.
  - At the end of the cycle:
    - Capture res_out<=alu_res and acc<=alu_res, with err=0.
    - Increment op_count.
    - Go to DONE.
  - CLEAR captures alu_res as for any other opcode; the multiplexer supplies 0.
- DONE:
  - op_ready=0, sel=0 and res_valid=1.
  - res_out and err are held stable until res_ready=1.
  - On res_ready=1, go to IDLE.
  - res_valid falls in the following cycle.
- Latency, with the handshake at edge N:
  - sel is asserted during cycle N+1.
  - res_valid=1 from cycle N+2.
  - Minimum issue interval is 3 cycles.
  - op_ready is purely state-decoded, with no combinational path from res_ready.
- Inputs are ignored whenever op_ready=0.
- Operand changes after acceptance do not affect alu_a or alu_b.
- sel is always either all-zero or exactly one-hot; it never has multiple bits set.
- Arithmetic is done by the downstream units. This block does not interpret alu_res; it captures it truncated to WIDTH.
- op_count wraps from 255 to 0; illegal opcodes do not increment it.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> all outputs 0 and op_ready=1 one cycle after release. Assert reset while in EXEC -> state IDLE, res_valid never rises.
- opcode=0, a_in=0x00FF, b_in=0x0F0F, bench mux model returns 0x000F -> sel=0x001 for one cycle at N+1; res_out=0x000F, acc=0x000F, res_valid at N+2, op_count=1.
- opcode=8 (SUB), a_in=0x0005, b_in=0x0007 -> sel=0x100 and sub_mode=1 during EXEC only; result 0xFFFE captured.
- use_acc=1 with acc=0x1234, opcode=7 (ADD), b_in=0x0001, a_in=0xFFFF -> alu_a=0x1234; result 0x1235 captured into acc.
- opcode=13 -> err=1, res_out=0, sel remains 0x000 throughout, acc and op_count unchanged.
- Hold res_ready=0 for 5 cycles while op_valid stays 1 -> res_valid and res_out stable, op_ready=0, no new accept. Raise res_ready -> IDLE, then the next op is accepted. Run 256 legal ops -> op_count wraps to 0.
